// File: rtl/systolic_matmul_engine.sv
// N x N output-stationary systolic matrix multiplier with valid/ready streaming.
// Define MATMUL_SATURATE_EN for saturating accumulation with a sticky ovf flag.
module systolic_matmul_engine #(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [N*DATA_W-1:0]    in_a,
  input  logic [N*DATA_W-1:0]    in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*N*ACC_W-1:0]   result,
  output logic                   ovf
);

  localparam int MUL_W = 2 * DATA_W;
  localparam int CNT_W = $clog2(2 * N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               accept, clr, latch;

  // Skew delay lines: row i of A is tapped at depth i, column j of B at depth j.
  logic [N-1:0][N-1:0][DATA_W-1:0] a_sk, b_sk;
  logic [N-1:0][N-1:0][DATA_W-1:0] pe_a, pe_b, a_in, b_in;
  logic [N-1:0][N-1:0][ACC_W-1:0]  acc, prod, acc_nx, result_q;

`ifdef MATMUL_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic [N-1:0][N-1:0][ACC_W:0] sum;
  logic [N-1:0][N-1:0]          clamp, pe_ovf;
  logic                         ovf_q;
`endif

  assign accept    = in_valid & in_ready;
  assign in_ready  = !reset && (state == IDLE || state == LOAD);
  assign out_valid = (state == DONE);
  assign result    = result_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_nx = state;
    clr      = 1'b0;
    latch    = 1'b0;
    case (state)
      IDLE:  if (accept) begin
               clr      = 1'b1;
               state_nx = in_last ? DRAIN : LOAD;
             end
      LOAD:  if (accept && in_last) state_nx = DRAIN;
      DRAIN: if (cnt == CNT_LAST) begin
               latch    = 1'b1;
               state_nx = DONE;
             end
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments.
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == DRAIN) ? cnt + 1'b1 : '0;
    end
  end

  // Operand routing and per-PE multiply-accumulate.
  always_comb begin
    a_in   = '0;
    b_in   = '0;
    prod   = '0;
    acc_nx = '0;
`ifdef MATMUL_SATURATE_EN
    sum    = '0;
    clamp  = '0;
`endif
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = a_sk[i][i];
      b_in[0][i] = b_sk[i][i];
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = pe_a[i][j-1];
        b_in[j][i] = pe_b[j-1][i];
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod[i][j] = ACC_W'(MUL_W'($signed(a_in[i][j])) * MUL_W'($signed(b_in[i][j])));
`ifdef MATMUL_SATURATE_EN
        sum[i][j]   = {acc[i][j][ACC_W-1], acc[i][j]} + {prod[i][j][ACC_W-1], prod[i][j]};
        clamp[i][j] = sum[i][j][ACC_W] != sum[i][j][ACC_W-1];
        if (!clamp[i][j])          acc_nx[i][j] = sum[i][j][ACC_W-1:0];
        else if (sum[i][j][ACC_W]) acc_nx[i][j] = ACC_MIN;
        else                       acc_nx[i][j] = ACC_MAX;
`else
        acc_nx[i][j] = acc[i][j] + prod[i][j];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: skew lines and accumulators are flops, not RAM, so they reset cleanly with the rest.
    if (reset) begin
      a_sk     <= '0;
      b_sk     <= '0;
      pe_a     <= '0;
      pe_b     <= '0;
      acc      <= '0;
      result_q <= '0;
`ifdef MATMUL_SATURATE_EN
      pe_ovf   <= '0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      // Unaccepted cycles inject zero operands so bubbles contribute nothing.
      for (int i = 0; i < N; i++) begin
        a_sk[i][0] <= accept ? in_a[i*DATA_W +: DATA_W] : '0;
        b_sk[i][0] <= accept ? in_b[i*DATA_W +: DATA_W] : '0;
        for (int d = 1; d < N; d++) begin
          a_sk[i][d] <= a_sk[i][d-1];
          b_sk[i][d] <= b_sk[i][d-1];
        end
      end
      pe_a <= a_in;
      pe_b <= b_in;
      acc  <= clr ? '0 : acc_nx;
      if (latch) result_q <= acc;
`ifdef MATMUL_SATURATE_EN
      pe_ovf <= clr ? '0 : (pe_ovf | clamp);
      if (clr)        ovf_q <= 1'b0;
      else if (latch) ovf_q <= |pe_ovf;
`endif
    end
  end

`ifdef MATMUL_SATURATE_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Directed self-checking bench for systolic_matmul_engine (N=2, DATA_W=8, ACC_W=16).
module tb_systolic_matmul_engine;

  localparam int N      = 2;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

`ifdef MATMUL_SATURATE_EN
  localparam int   OVF_C00  = 32767;
  localparam logic OVF_FLAG = 1'b1;
`else
  localparam int   OVF_C00  = -16384;
  localparam logic OVF_FLAG = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_last = 1'b0;
  logic                   out_ready = 1'b0;
  logic [N*DATA_W-1:0]    in_a = '0;
  logic [N*DATA_W-1:0]    in_b = '0;
  logic                   in_ready, out_valid, ovf;
  logic [N*N*ACC_W-1:0]   result;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  systolic_matmul_engine #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic signed [63:0] c(input int i, input int j);
    logic signed [ACC_W-1:0] v;
    v = result[(i*N+j)*ACC_W +: ACC_W];
    return 64'(v);
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_tile(input string tag, input int e00, input int e01, input int e10, input int e11);
    check({tag, "_c00"}, c(0, 0), 64'(e00));
    check({tag, "_c01"}, c(0, 1), 64'(e01));
    check({tag, "_c10"}, c(1, 0), 64'(e10));
    check({tag, "_c11"}, c(1, 1), 64'(e11));
  endtask

  // One accepted beat: A column (a0,a1) and B row (b0,b1).
  task automatic beat(input int a0, input int a1, input int b0, input int b1, input logic last);
    @(negedge clk);
    check("in_ready_beat", 64'(in_ready), 64'(1));
    in_a     = {DATA_W'(a1), DATA_W'(a0)};
    in_b     = {DATA_W'(b1), DATA_W'(b0)};
    in_valid = 1'b1;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b1;
    in_a     = 16'hA5A5;
    in_b     = 16'h5A5A;
  endtask

  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(4));
    check({tag, "_in_ready_done"}, 64'(in_ready), 64'(0));
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 64'(out_valid), 64'(0));
    check({tag, "_idle_ready"}, 64'(in_ready), 64'(1));
  endtask

  task automatic basic_beats();
    beat(1, 3, 5, 6, 1'b0);
    beat(2, 4, 7, 8, 1'b1);
  endtask

  initial begin
    logic seen;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    check_tile("rst", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'(1));

    // Basic 2x2, K=2
    basic_beats();
    wait_result("basic");
    check_tile("basic", 19, 22, 43, 50);
    check("basic_ovf", 64'(ovf), 64'(0));
    take("basic");

    // Signed extremes, K=1
    beat(-128, 127, -128, -1, 1'b1);
    wait_result("signed");
    check_tile("signed", 16384, 128, -16256, -127);
    take("signed");

    // Bubbles between beats and downstream backpressure
    beat(1, 3, 5, 6, 1'b0);
    repeat (3) @(posedge clk);
    beat(2, 4, 7, 8, 1'b1);
    wait_result("bp");
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(out_valid), 64'(1));
      check("bp_hold_in_ready", 64'(in_ready), 64'(0));
    end
    check_tile("bp", 19, 22, 43, 50);
    take("bp");

    // Back-to-back tiles: accumulators must clear between them
    basic_beats();
    wait_result("b2b_first");
    check_tile("b2b_first", 19, 22, 43, 50);
    take("b2b_first");
    beat(1, 0, 9, -9, 1'b0);
    beat(0, 1, 3, 2, 1'b1);
    wait_result("b2b_ident");
    check_tile("b2b_ident", 9, -9, 3, 2);
    take("b2b_ident");

    // Reset during DRAIN discards the tile
    basic_beats();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("rst_drain_no_valid", 64'(seen), 64'(0));
    check_tile("rst_drain", 0, 0, 0, 0);
    check("rst_drain_ready", 64'(in_ready), 64'(1));
    basic_beats();
    wait_result("post_rst");
    check_tile("post_rst", 19, 22, 43, 50);
    take("post_rst");

    // Accumulator overflow at ACC_W=16
    beat(-128, 0, -128, 0, 1'b0);
    beat(-128, 0, -128, 0, 1'b0);
    beat(-128, 0, -128, 0, 1'b1);
    wait_result("ovf");
    check_tile("ovf", OVF_C00, 0, 0, 0);
    check("ovf_flag", 64'(ovf), 64'(OVF_FLAG));
    take("ovf");

    // A fresh tile clears the overflow flag
    beat(-128, 127, -128, -1, 1'b1);
    wait_result("ovf_clear");
    check_tile("ovf_clear", 16384, 128, -16256, -127);
    check("ovf_clear_flag", 64'(ovf), 64'(0));
    take("ovf_clear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/systolic_matmul_engine.md
Name: systolic_matmul_engine

Overview:
- Parametrised N x N output-stationary systolic matrix multiplier with valid/ready streaming on input and result sides; successor to the fixed 2x2 core.
- Streams K (run-time length) outer-product beats: column k of A and row k of B per beat. Skews them internally across an N x N PE grid, then presents the full C = A x B tile on one flat bus.
- Sits between the operand fetch logic and the result writeback path of the tensor core.

Parameters:
- N, 2, matrix tile dimension (PE grid is N x N), N >= 1
- DATA_W, 8, signed operand width
- ACC_W, 32, signed accumulator/result width, ACC_W >= 2*DATA_W

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  engine accepts beat
- in_last  in  1  marks final beat (k = K-1) of current product
- in_a  in  N*DATA_W  A[i][k] at bits [i*DATA_W +: DATA_W]
- in_b  in  N*DATA_W  B[k][j] at bits [j*DATA_W +: DATA_W]
- out_valid  out  1  result tile valid
- out_ready  in  1  downstream accepts tile
- result  out  N*N*ACC_W  C[i][j] at bits [(i*N+j)*ACC_W +: ACC_W]
- ovf  out  1  sticky overflow flag for current tile (see Optional Feature)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All state updates on posedge clk.
- Reset values: in_ready=0 on the reset cycle, then 1 (IDLE), out_valid=0, result=0, ovf=0, all PE accumulators and skew registers 0, FSM=IDLE.
- FSM states:
  - IDLE: in_ready=1. On the first accepted beat, clear all accumulators, then accumulate; go to LOAD. If that beat has in_last=1, go directly to DRAIN.
  - LOAD: in_ready=1. Each accepted beat (in_valid & in_ready) enters the skew. Accepted beat with in_last -> DRAIN. Cycles with in_valid=0 insert bubbles (zero operands); results are unaffected.
  - DRAIN: in_ready=0. Counts 2N-1 cycles so the last skewed operands reach PE[N-1][N-1]. Then latch all accumulators into result -> DONE.
  - DONE: out_valid=1; result and ovf held stable. On out_valid & out_ready -> IDLE with out_valid=0 the next cycle. in_ready=0 while DONE (no overlap).
- Latency: out_valid rises exactly 2N cycles after the edge that accepts in_last (N=2 -> 4 cycles).
- Skew: row i of A is delayed i cycles; column j of B is delayed j cycles. PE passes a right and b down with 1-cycle registers.
- Arithmetic: signed DATA_W x DATA_W product, sign-extended to ACC_W. Accumulation wraps modulo 2^ACC_W by default.
- K has no upper bound. K=1 is legal (single outer product).
- in_last while out_ready is asserted in DONE: impossible, since in_ready=0.
- in_a/in_b/in_last are ignored when in_valid=0.
- Reset mid-operation: any state returns to IDLE next cycle. Partial sums are discarded and out_valid drops.

Optional Feature:
- Macro MATMUL_SATURATE_EN.
- Defined: each accumulate clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. ovf goes high and sticks for the tile if any PE clamped. ovf clears when a new tile's first beat is accepted.
- Undefined: wrap-around accumulation; ovf tied 0.

Test Plan:
- Basic, N=2: beats (a=(1,3), b=(5,6)), then (a=(2,4), b=(7,8), last) -> result C=[[19,22],[43,50]]; out_valid exactly 4 cycles after last accepted.
- Signed, N=2, K=1: a=(-128,127), b=(-128,-1), last -> C=[[16384,128],[-16256,-127]].
- Backpressure and bubbles: hold in_valid=0 for 3 cycles between beats, and hold out_ready=0 for 5 cycles in DONE -> result unchanged (same as basic case), in_ready=0 throughout DONE, single handshake returns to IDLE.
- Back-to-back tiles: basic case, then the identity test A=I, B=[[9,-9],[3,2]] -> second result exact. Accumulators are cleared between tiles.
- Reset mid-DRAIN: assert reset 1 cycle after last -> out_valid never rises, result=0. A following basic case produces the correct C.
- Overflow, ACC_W=16, N=2: 3 beats each a=(-128,0), b=(-128,0) -> C[0][0] = -16384 (wrap) without the macro; 32767 with ovf=1 when MATMUL_SATURATE_EN is defined.
